mips_multicycle: RTL and testbench
==================================

# mips_multicycle

Multicycle successor to the single-cycle MIPS core. It executes the same instruction subset through a control FSM that spends 3–5 cycles per instruction and shares one ALU and one unified memory port. The memory port is variable-latency with a req/ack handshake, so the core stalls on slow memory. Illegal opcodes and misaligned accesses send the core to a sticky halt state. It sits at the top of the processor, in place of the single-cycle core, with an external unified memory.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of `mem_addr`; carries `addr[ADDR_W-1:0]`.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while `mem_req` = 1.
- mem_addr  out  ADDR_W  byte address, always word-aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; sampled on the cycle `mem_ack` = 1.
- mem_ack  in  1  transaction completes on this cycle; ignored while `mem_req` = 0.
- halt  out  1  core is in HALT.
- pc_dbg  out  32  current PC.

## Operation
- **Supported instructions:** R-type add/sub/and/or/slt (opcode 0), addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- **Internal registers:** PC, IR, A, B, ALUOut, MDR.
- **Register file:** 32×32, all entries zeroed on reset. Writes to $0 are discarded; $0 always reads 0.
- **FSM states and transitions:**
  - START → FETCH.
  - FETCH: request with `mem_addr` = PC and `mem_we` = 0. On ack: IR ← `mem_rdata`, PC ← PC+4, go to DECODE.
  - DECODE: A ← rf[rs], B ← rf[rt], ALUOut ← PC + (sext(imm) << 2). Dispatch to EXEC_R, EXEC_I, MEM_ADDR, BRANCH or JUMP. Any other opcode, or an unsupported funct, goes to HALT.
  - EXEC_R: ALUOut ← A op B → ALU_WB, which writes rd.
  - EXEC_I: ALUOut ← A + sext(imm) → ALU_WB, which writes rt.
  - MEM_ADDR: ALUOut ← A + sext(imm). If addr[1:0] ≠ 0 → HALT; else lw → MEM_RD, sw → MEM_WR.
  - MEM_RD: read request at ALUOut. On ack: MDR ← `mem_rdata`, go to MEM_WB; MEM_WB writes MDR to rt, then → FETCH.
  - MEM_WR: write request at ALUOut with `mem_wdata` = B. On ack → FETCH.
  - BRANCH: if A == B, PC ← ALUOut. Then → FETCH.
  - JUMP: PC ← {PC[31:28], IR[25:0], 2'b00}. Then → FETCH.
  - HALT: absorbing; left only by reset.
- **Arithmetic:** 32-bit, wrap-around, no overflow exception. slt is signed.
- **Handshake:**
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are decoded from the state only.
  - They stay stable until the ack cycle.
  - Waiting is unbounded; there is no timeout.

## Timing
- **Reset values:** state START, PC = RESET_PC, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `halt` = 0, `pc_dbg` = RESET_PC.
- **Outputs during reset:**
  - `mem_addr` and `mem_wdata` read 0 whenever `mem_req` = 0.
  - Reset asserted mid-transaction drops `mem_req` asynchronously; the in-flight access is abandoned.
- **After reset release:** first cycle is START; `mem_req` first rises on the second cycle.
- **Cycles per instruction with a same-cycle ack:**
  - beq, j: 3.
  - R-type, addi, sw: 4.
  - lw: 5.
- **Wait states:** each cycle of ack delay adds exactly one cycle.
- **Register file:** write occurs at the end of ALU_WB or MEM_WB; the value is visible to the next instruction's DECODE.
- **Halt entry:** `halt` rises on the cycle after entering HALT. `mem_req` stays 0 from then on.

## Structure
- **Package `mips_pkg`:**
  - Opcode and funct constants.
  - FSM state enum.
  - ALU operation codes (4-bit, same encoding as the existing ALU control).
- **Sub-modules:**
  - The FSM is a natural sub-module: `mips_mc_control`, with inputs opcode, funct, zero and `mem_ack`, producing all enables and mux selects.
  - The datapath reuses the existing `alu` and `reg_file` blocks. `reg_file` gains the async active-low reset.

## Test plan
- **Linear program:** addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x40($0); lw $4,0x40($0) with a same-cycle ack → mem[0x40] = 12, $4 = 12, total 4+4+4+4+5 = 21 cycles after START.
- **Wait states:** repeat the linear program with 3 ack-delay cycles on every access → each instruction lengthens by 3×(number of its accesses); request signals stay stable throughout the wait.
- **Branch and jump:**
  - beq $1,$1,+2 at 0x0 → next fetch at 0xC.
  - beq not taken → next fetch at 0x4.
  - j 0x100 at 0x10 → next fetch at 0x400.
- **Traps:**
  - Opcode 0x3F → `halt` = 1, no further `mem_req`.
  - lw at address 0x42 → halt, no data request issued.
- **Register $0:** add $0,$1,$2 → $0 still reads 0.
- **Reset mid-MEM_RD wait:** `mem_req` drops immediately. After release, the first fetch is at RESET_PC on the second cycle, and all registers read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, funct codes,
// ALU operation encoding, control FSM states and control/bus payloads.
package mips_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned RIDX_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_op_e;

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_e;

  typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} srcb_e;
  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP} pc_src_e;

  // Per-cycle datapath enables and mux selects.
  typedef struct packed {
    logic    pc_we;
    pc_src_e pc_src;
    logic    ir_we;
    logic    ab_we;
    logic    alu_out_we;
    logic    mdr_we;
    logic    rf_we;
    logic    rf_dst_rd;
    logic    rf_from_mdr;
    logic    src_a_pc;
    srcb_e   src_b;
    alu_op_e alu_op;
  } ctrl_t;

  // Memory request shape for the state being entered.
  typedef struct packed {
    logic req;
    logic we;
    logic from_pc;
  } bus_t;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  function automatic alu_op_e funct_to_op(input logic [5:0] f);
    alu_op_e op;
    op = ALU_ADD;
    case (f)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] alu_eval(input alu_op_e op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] y;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = XLEN'($signed(a) < $signed(b));
      default: y = a + b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mips_mc_control.sv
// Multicycle control FSM.
// Inputs : opcode/funct of IR, ALU zero, misaligned address flag, mem_ack.
// Outputs: state_o (current state), ctrl_c_o (datapath enables for this
//          cycle), bus_c_o (memory request for the state being entered).
module mips_mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       misaligned_i,
  input  logic       mem_ack_i,
  output state_e     state_o,
  output ctrl_t      ctrl_c_o,
  output bus_t       bus_c_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_START;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ctrl_c_o = '0;
    bus_c_o  = '0;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        ctrl_c_o.src_a_pc = 1'b1;
        ctrl_c_o.src_b    = SRCB_FOUR;
        ctrl_c_o.alu_op   = ALU_ADD;
        if (mem_ack_i) begin
          ctrl_c_o.ir_we  = 1'b1;
          ctrl_c_o.pc_we  = 1'b1;
          ctrl_c_o.pc_src = PC_ALU;
          state_d         = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here from the already-incremented PC.
        ctrl_c_o.ab_we      = 1'b1;
        ctrl_c_o.alu_out_we = 1'b1;
        ctrl_c_o.src_a_pc   = 1'b1;
        ctrl_c_o.src_b      = SRCB_IMM_SH2;
        ctrl_c_o.alu_op     = ALU_ADD;
        case (opcode_i)
          OP_RTYPE: state_d = funct_ok(funct_i) ? S_EXEC_R : S_HALT;
          OP_ADDI:  state_d = S_EXEC_I;
          OP_LW,
          OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          default:  state_d = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        ctrl_c_o.alu_out_we = 1'b1;
        ctrl_c_o.src_b      = SRCB_B;
        ctrl_c_o.alu_op     = funct_to_op(funct_i);
        state_d             = S_ALU_WB;
      end
      S_EXEC_I: begin
        ctrl_c_o.alu_out_we = 1'b1;
        ctrl_c_o.src_b      = SRCB_IMM;
        ctrl_c_o.alu_op     = ALU_ADD;
        state_d             = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctrl_c_o.rf_we     = 1'b1;
        ctrl_c_o.rf_dst_rd = (opcode_i == OP_RTYPE);
        state_d            = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl_c_o.alu_out_we = 1'b1;
        ctrl_c_o.src_b      = SRCB_IMM;
        ctrl_c_o.alu_op     = ALU_ADD;
        if (misaligned_i)           state_d = S_HALT;
        else if (opcode_i == OP_LW) state_d = S_MEM_RD;
        else                        state_d = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ack_i) begin
          ctrl_c_o.mdr_we = 1'b1;
          state_d         = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        ctrl_c_o.rf_we       = 1'b1;
        ctrl_c_o.rf_from_mdr = 1'b1;
        state_d              = S_FETCH;
      end
      S_MEM_WR: if (mem_ack_i) state_d = S_FETCH;
      S_BRANCH: begin
        ctrl_c_o.src_b  = SRCB_B;
        ctrl_c_o.alu_op = ALU_SUB;
        ctrl_c_o.pc_src = PC_ALUOUT;
        ctrl_c_o.pc_we  = zero_i;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        ctrl_c_o.pc_we  = 1'b1;
        ctrl_c_o.pc_src = PC_JUMP;
        state_d         = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    // Request signals follow the state alone; they are registered in the top.
    bus_c_o.req     = (state_d == S_FETCH) || (state_d == S_MEM_RD) ||
                      (state_d == S_MEM_WR);
    bus_c_o.we      = (state_d == S_MEM_WR);
    bus_c_o.from_pc = (state_d == S_FETCH);
  end

  assign state_o = state_q;

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core with one shared ALU and one unified memory port.
// Ports: clk, reset (async active-low); mem_req/mem_we/mem_addr/mem_wdata
// request a word access, mem_rdata/mem_ack complete it; halt flags the
// sticky trap state; pc_dbg exposes the current PC.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              halt,
  output logic [31:0]       pc_dbg
);

  logic [XLEN-1:0]   pc_q, pc_d, ir_q, a_q, b_q, alu_out_q, alu_out_d, mdr_q;
  logic [XLEN-1:0]   rf_q [NREG];
  logic [XLEN-1:0]   src_a, src_b, alu_y, imm_sext, wb_data;
  logic [RIDX_W-1:0] rs, rt, rd, wb_idx;
  logic              mem_req_q, mem_we_q, halt_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  ctrl_t             ctrl;
  bus_t              bus;
  state_e            state;

  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  mips_mc_control u_ctrl (
    .clk          (clk),
    .rst_n        (reset),
    .opcode_i     (ir_q[31:26]),
    .funct_i      (ir_q[5:0]),
    .zero_i       (alu_y == '0),
    .misaligned_i (alu_y[1:0] != 2'b00),
    .mem_ack_i    (mem_ack),
    .state_o      (state),
    .ctrl_c_o     (ctrl),
    .bus_c_o      (bus)
  );

  // Shared ALU operand selection.
  always_comb begin
    src_a = ctrl.src_a_pc ? pc_q : a_q;
    case (ctrl.src_b)
      SRCB_B:       src_b = b_q;
      SRCB_FOUR:    src_b = XLEN'(4);
      SRCB_IMM:     src_b = imm_sext;
      SRCB_IMM_SH2: src_b = {imm_sext[XLEN-3:0], 2'b00};
      default:      src_b = b_q;
    endcase
    alu_y = alu_eval(ctrl.alu_op, src_a, src_b);
  end

  always_comb begin
    pc_d = pc_q;
    if (ctrl.pc_we) begin
      case (ctrl.pc_src)
        PC_ALU:    pc_d = alu_y;
        PC_ALUOUT: pc_d = alu_out_q;
        PC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        default:   pc_d = pc_q;
      endcase
    end
    alu_out_d = ctrl.alu_out_we ? alu_y : alu_out_q;
    // Address/data are zero whenever no request is pending.
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (bus.req) mem_addr_d = ADDR_W'(bus.from_pc ? pc_d : alu_out_d);
    if (bus.req && bus.we) mem_wdata_d = b_q;
    wb_idx  = ctrl.rf_dst_rd ? rd : rt;
    wb_data = ctrl.rf_from_mdr ? mdr_q : alu_out_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      alu_out_q <= alu_out_d;
      if (ctrl.ir_we)  ir_q  <= mem_rdata;
      if (ctrl.mdr_we) mdr_q <= mem_rdata;
      if (ctrl.ab_we) begin
        a_q <= rf_q[rs];
        b_q <= rf_q[rt];
      end
    end
  end

  // Register file; $0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (ctrl.rf_we && (wb_idx != '0)) begin
      rf_q[wb_idx] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halt_q      <= 1'b0;
    end else begin
      mem_req_q   <= bus.req;
      mem_we_q    <= bus.req && bus.we;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halt_q      <= (state == S_HALT);
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign halt      = halt_q;
  assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle with a variable-latency memory model.
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, halt;
  logic [31:0] mem_addr, mem_wdata, pc_dbg;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_multicycle #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halt      (halt),
    .pc_dbg    (pc_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model, transaction log and protocol monitors.
  logic [31:0] mem [512];
  int          delay = 0;
  int          cnt = 0;
  int          cyc = 0;
  logic [31:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  int          wr_count = 0;
  int          stable_err = 0;
  int          req_after_halt = 0;
  logic        l_we;
  logic [31:0] l_addr, l_wdata;

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset || !mem_req) begin
      mem_ack = 1'b0;
      cnt     = 0;
    end else begin
      if (cnt == 0) begin
        if (!mem_we) begin
          rd_addr_q.push_back(mem_addr);
          rd_cyc_q.push_back(cyc);
        end else begin
          wr_count++;
        end
        l_we = mem_we; l_addr = mem_addr; l_wdata = mem_wdata;
      end else if (mem_we !== l_we || mem_addr !== l_addr || mem_wdata !== l_wdata) begin
        stable_err++;
      end
      if (cnt == delay) begin
        mem_ack = 1'b1;
        if (mem_we) mem[mem_addr[10:2]] = mem_wdata;
        else        mem_rdata = mem[mem_addr[10:2]];
        cnt = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        cnt++;
      end
    end
    if (halt && mem_req) req_after_halt++;
  end

  function automatic logic [31:0] rd_addr_at(input int i);
    if (i < rd_addr_q.size()) return rd_addr_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rd_cyc_at(input int i);
    if (i < rd_cyc_q.size()) return 32'(rd_cyc_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] memw(input logic [31:0] a);
    return mem[a[10:2]];
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[10:2]] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  task automatic load_linear();
    clear_mem();
    put(32'h00, 32'h2001_0005); // addi $1,$0,5
    put(32'h04, 32'h2002_0007); // addi $2,$0,7
    put(32'h08, 32'h0022_1820); // add  $3,$1,$2
    put(32'h0C, 32'hAC03_0040); // sw   $3,0x40($0)
    put(32'h10, 32'h8C04_0040); // lw   $4,0x40($0)
    put(32'h14, 32'hAC04_0044); // sw   $4,0x44($0)
    put(32'h18, 32'h0022_0020); // add  $0,$1,$2
    put(32'h1C, 32'hAC00_0048); // sw   $0,0x48($0)
    put(32'h20, 32'h0022_2822); // sub  $5,$1,$2   -> -2
    put(32'h24, 32'h00A1_302A); // slt  $6,$5,$1   -> 1
    put(32'h28, 32'h00A2_3824); // and  $7,$5,$2   -> 6
    put(32'h2C, 32'h00E1_3825); // or   $7,$7,$1   -> 7
    put(32'h30, 32'hAC05_0080); // sw   $5,0x80($0)
    put(32'h34, 32'hAC06_0084); // sw   $6,0x84($0)
    put(32'h38, 32'hAC07_0088); // sw   $7,0x88($0)
    put(32'h3C, 32'hFC00_0000); // illegal opcode 0x3F
  endtask

  task automatic hold_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rd_addr_q.delete();
    rd_cyc_q.delete();
    wr_count       = 0;
    stable_err     = 0;
    req_after_halt = 0;
    #1 reset = 1'b1;
  endtask

  task automatic run_until_halt(input string tag, input int budget, output int hcyc);
    hcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (halt) begin
        hcyc = cyc;
        break;
      end
    end
    if (hcyc < 0) check({tag, "_timeout"}, 32'(halt), 32'h1);
    repeat (5) @(negedge clk);
    #1;
    check({tag, "_no_req_after_halt"}, 32'(req_after_halt), 32'h0);
  endtask

  int hc;

  initial begin
    // Reset values
    load_linear();
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_pc_dbg", pc_dbg, 32'h0);

    // Linear program, same-cycle ack
    delay = 0;
    release_reset();
    #1 check("start_no_req", 32'(mem_req), 32'h0);
    run_until_halt("lin", 500, hc);
    check("lin_first_fetch_cyc", rd_cyc_at(0), 32'd1);
    check("lin_lw_fetch_cyc", rd_cyc_at(4), 32'd17);
    check("lin_lw_data_addr", rd_addr_at(5), 32'h40);
    check("lin_lw_data_cyc", rd_cyc_at(5), 32'd20);
    check("lin_after_lw_addr", rd_addr_at(6), 32'h14);
    check("lin_after_lw_cyc", rd_cyc_at(6), 32'd22);
    check("lin_mem40", memw(32'h40), 32'd12);
    check("lin_mem44_r4", memw(32'h44), 32'd12);
    check("lin_r0_zero", memw(32'h48), 32'h0);
    check("lin_sub", memw(32'h80), 32'hFFFF_FFFE);
    check("lin_slt", memw(32'h84), 32'h1);
    check("lin_and_or", memw(32'h88), 32'h7);
    check("lin_halt_pc", pc_dbg, 32'h40);

    // Linear program, 3 wait states per access
    hold_reset();
    load_linear();
    delay = 3;
    release_reset();
    run_until_halt("wait", 1000, hc);
    check("wait_fetch2_cyc", rd_cyc_at(1), 32'd8);
    check("wait_lw_fetch_cyc", rd_cyc_at(4), 32'd32);
    check("wait_lw_data_cyc", rd_cyc_at(5), 32'd38);
    check("wait_after_lw_cyc", rd_cyc_at(6), 32'd43);
    check("wait_req_stable", 32'(stable_err), 32'h0);
    check("wait_mem44_r4", memw(32'h44), 32'd12);
    check("wait_and_or", memw(32'h88), 32'h7);

    // Branch taken / not taken and jump
    hold_reset();
    clear_mem();
    put(32'h000, 32'h1021_0002); // beq $1,$1,+2
    put(32'h00C, 32'h2005_0009); // addi $5,$0,9
    put(32'h010, 32'h0800_0100); // j 0x100
    put(32'h400, 32'h2001_0001); // addi $1,$0,1
    put(32'h404, 32'h1020_0003); // beq $1,$0,+3 (not taken)
    put(32'h408, 32'hFC00_0000);
    delay = 0;
    release_reset();
    run_until_halt("bj", 500, hc);
    check("beq_taken_addr", rd_addr_at(1), 32'h00C);
    check("beq_taken_cyc", rd_cyc_at(1), 32'd4);
    check("j_target_addr", rd_addr_at(3), 32'h400);
    check("j_target_cyc", rd_cyc_at(3), 32'd11);
    check("beq_not_taken_addr", rd_addr_at(5), 32'h408);
    check("beq_not_taken_cyc", rd_cyc_at(5), 32'd18);

    // Misaligned load traps before any data request
    hold_reset();
    clear_mem();
    put(32'h0, 32'h8C04_0042); // lw $4,0x42($0)
    release_reset();
    run_until_halt("misal", 100, hc);
    check("misal_halt_cyc", 32'(hc), 32'd5);
    check("misal_reads", 32'(rd_addr_q.size()), 32'd1);
    check("misal_writes", 32'(wr_count), 32'd0);
    check("misal_pc", pc_dbg, 32'h4);

    // Reset during an lw data wait
    hold_reset();
    load_linear();
    delay = 3;
    release_reset();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (rd_addr_q.size() > 5) break;
    end
    check("mid_lw_addr", rd_addr_at(5), 32'h40);
    check("mid_lw_req_high", 32'(mem_req), 32'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_req_drop", 32'(mem_req), 32'h0);
    check("mid_rst_addr_zero", mem_addr, 32'h0);
    clear_mem();
    put(32'h0, 32'hAC01_0080); // sw $1,0x80($0)
    put(32'h4, 32'hAC03_0084); // sw $3,0x84($0)
    put(32'h8, 32'hAC04_0088); // sw $4,0x88($0)
    put(32'hC, 32'hFC00_0000);
    delay = 0;
    repeat (2) @(negedge clk);
    release_reset();
    run_until_halt("post", 200, hc);
    check("post_first_addr", rd_addr_at(0), 32'h0);
    check("post_first_cyc", rd_cyc_at(0), 32'd1);
    check("post_r1_zero", memw(32'h80), 32'h0);
    check("post_r3_zero", memw(32'h84), 32'h0);
    check("post_r4_zero", memw(32'h88), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
